lut_mult_serial: RTL and testbench

//  Runtime-loadable coefficient multiplier, nibble-serial. Computes P = X * A.
//  - On a coefficient load, builds a 16-word table of k*A (k = 0..15).
//  - Then consumes X one 4-bit digit per cycle, MSB digit first, using Horner accumulation.
//  - Generalises the fixed-constant, 8-bit-only LUT multiplier: width-parametrised, coefficient

---
 rtl/lut_mult_serial.sv | 144 ++++++++++++++
 tb/tb_lut_mult_serial.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_mult_serial.sv
// Nibble-serial multiplier P = X * A. A 16-entry k*A table is rebuilt on every coefficient load.
// Define LUT_MULT_SIGNED_EN for two's-complement X, A and P. The default build is unsigned.
module lut_mult_serial #(
    parameter int X_W = 16,
    parameter int A_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coef_load,
    input  logic [A_W-1:0]     coef_in,
    output logic               coef_busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [X_W-1:0]     x_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [X_W+A_W-1:0] p_out
);
    localparam int NIB   = X_W / 4;
    localparam int P_W   = X_W + A_W;
    localparam int E_W   = A_W + 4;
    localparam int CNT_W = (NIB > 16) ? $clog2(NIB) : 4;

    typedef enum logic [2:0] {S_EMPTY, S_FILL, S_READY, S_MUL, S_DONE} state_t;
    state_t state, state_nx;

    logic [CNT_W-1:0] cnt;
    logic [A_W-1:0]   coef;
    logic [E_W-1:0]   fill_sum;
    logic [E_W-1:0]   lut [16];
    logic [X_W-1:0]   x_sh;
    logic [P_W-1:0]   acc;
    logic [3:0]       digit;
    logic [E_W-1:0]   entry;
    logic [E_W-1:0]   coef_ext;
    logic [P_W-1:0]   term;
    logic [P_W-1:0]   acc_nx;
    logic             load_ok;
    logic             take_x;
    logic             fill_last;
    logic             mul_last;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is only ever high in READY, and a coefficient load there takes priority.
    assign load_ok   = coef_load && (state == S_EMPTY || state == S_READY);
    assign take_x    = in_valid && in_ready;
    assign fill_last = (cnt == CNT_W'(15));
    assign mul_last  = (cnt == CNT_W'(NIB - 1));
    assign digit     = x_sh[X_W-1 -: 4];
    assign entry     = lut[digit];

`ifdef LUT_MULT_SIGNED_EN
    assign coef_ext = {{4{coef[A_W-1]}}, coef};
    // The leading digit carries the sign: its weight is d-16 when d[3] is set.
    always_comb begin
        term = {{(P_W-E_W){entry[E_W-1]}}, entry};
        if (cnt == '0 && digit[3])
            term = term - ({{(P_W-A_W){coef[A_W-1]}}, coef} << 4);
    end
`else
    assign coef_ext = {4'b0000, coef};
    assign term     = {{(P_W-E_W){1'b0}}, entry};
`endif

    assign acc_nx = (acc << 4) + term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        coef_busy = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_EMPTY: begin
                if (coef_load)
                    state_nx = S_FILL;
            end
            S_FILL: begin
                coef_busy = 1'b1;
                if (fill_last)
                    state_nx = S_READY;
            end
            S_READY: begin
                in_ready = !coef_load;
                if (coef_load)
                    state_nx = S_FILL;
                else if (in_valid)
                    state_nx = S_MUL;
            end
            S_MUL: begin
                coef_busy = 1'b1;
                if (mul_last)
                    state_nx = S_DONE;
            end
            S_DONE: begin
                coef_busy = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nx = S_READY;
            end
            default: state_nx = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            coef     <= '0;
            fill_sum <= '0;
            x_sh     <= '0;
            acc      <= '0;
        end else if (load_ok) begin
            coef     <= coef_in;
            cnt      <= '0;
            fill_sum <= '0;
        end else if (take_x) begin
            x_sh <= x_in;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == S_FILL) begin
            fill_sum <= fill_sum + coef_ext;
            cnt      <= cnt + CNT_W'(1);
        end else if (state == S_MUL) begin
            acc  <= acc_nx;
            x_sh <= x_sh << 4;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Table contents need no reset: they are only read in MUL, reachable only after a full FILL.
    always_ff @(posedge clk) begin
        if (state == S_FILL)
            lut[cnt[3:0]] <= fill_sum;
    end

    assign p_out = acc;

endmodule

// File: tb/tb_lut_mult_serial.sv
// Self-checking bench for lut_mult_serial (X_W=16, A_W=8), unsigned or LUT_MULT_SIGNED_EN build.
`timescale 1ns/1ps
module tb_lut_mult_serial;
    localparam int X_W = 16;
    localparam int A_W = 8;
    localparam int P_W = 24;
    localparam int NIB = 4;

`ifdef LUT_MULT_SIGNED_EN
    localparam logic [P_W-1:0] EXP_FFFF_FF = 24'h000001;
    localparam logic [P_W-1:0] EXP_8000_FD = 24'h018000;
    localparam logic [P_W-1:0] EXP_FFFF_05 = 24'hFFFFFB;
`else
    localparam logic [P_W-1:0] EXP_FFFF_FF = 24'hFEFF01;
    localparam logic [P_W-1:0] EXP_8000_FD = 24'h7E8000;
    localparam logic [P_W-1:0] EXP_FFFF_05 = 24'h04FFFB;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           coef_load = 1'b0;
    logic [A_W-1:0] coef_in = '0;
    logic           coef_busy;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [X_W-1:0] x_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [P_W-1:0] p_out;

    logic [P_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    lut_mult_serial #(.X_W(X_W), .A_W(A_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .coef_load(coef_load), .coef_in(coef_in), .coef_busy(coef_busy),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [P_W-1:0] model(input logic [X_W-1:0] x, input logic [A_W-1:0] a);
        longint xv;
        longint av;
`ifdef LUT_MULT_SIGNED_EN
        xv = longint'($signed(x));
        av = longint'($signed(a));
`else
        xv = longint'(x);
        av = longint'(a);
`endif
        return P_W'(xv * av);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every cycle a result is presented it must match the head of exp_q.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("p_out", 32'(p_out), 32'(exp_q[0]));
                if (out_ready)
                    void'(exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic load_coef(input logic [A_W-1:0] a);
        @(posedge clk); #1;
        coef_load = 1'b1;
        coef_in = a;
        @(posedge clk); #1;
        coef_load = 1'b0;
    endtask

    task automatic wait_ready();
        int busy;
        bit done;
        busy = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (coef_busy) begin
                busy++;
                check("in_ready_in_fill", 32'(in_ready), 32'd0);
            end else begin
                done = 1'b1;
            end
        end
        if (!done)
            check("fill_timeout", 32'd0, 32'd1);
        check("in_ready_after_fill", 32'(in_ready), 32'd1);
        check("fill_cycles", 32'(busy), 32'd16);
    endtask

    task automatic start(input logic [X_W-1:0] x, input logic [P_W-1:0] exp);
        @(posedge clk); #1;
        in_valid = 1'b1;
        x_in = x;
        @(negedge clk);
        check("in_ready_before_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        in_valid = 1'b0;
        x_in = X_W'($urandom_range(0, 65535));
    endtask

    task automatic wait_out(input int exp_lat);
        int lat;
        bit seen;
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat = i;
            end
        end
        if (!seen)
            check("out_valid_timeout", 32'd0, 32'd1);
        else
            check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic finish_out();
        @(posedge clk); #1;
        check("out_valid_drop", 32'(out_valid), 32'd0);
    endtask

    task automatic mult(input logic [X_W-1:0] x, input logic [P_W-1:0] exp);
        start(x, exp);
        wait_out(NIB + 1);
        finish_out();
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_coef_busy", 32'(coef_busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p_out", 32'(p_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // No table yet: input must be refused
        in_valid = 1'b1;
        x_in = 16'h00AA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("empty_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        // 1/2: load A=2, busy for 16 cycles, then 0x1234*2
        load_coef(8'h02);
        wait_ready();
        mult(16'h1234, 24'h002468);
        mult(16'h0003, 24'h000006);

        // 3: A=255, x=0xFFFF, output held under backpressure
        load_coef(8'hFF);
        wait_ready();
        out_ready = 1'b0;
        start(16'hFFFF, EXP_FFFF_FF);
        wait_out(NIB + 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        finish_out();

        // 4: load request during MUL is dropped
        load_coef(8'h02);
        wait_ready();
        start(16'h0003, 24'h000006);
        coef_load = 1'b1;
        coef_in = 8'h07;
        @(negedge clk);
        check("mul_coef_busy", 32'(coef_busy), 32'd1);
        @(posedge clk); #1;
        coef_load = 1'b0;
        wait_out(NIB);
        finish_out();
        mult(16'h0101, model(16'h0101, 8'h02));

        // 4: load and input together in READY: load wins
        @(posedge clk); #1;
        coef_load = 1'b1;
        coef_in = 8'h03;
        in_valid = 1'b1;
        x_in = 16'h0055;
        @(negedge clk);
        check("in_ready_load_wins", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        coef_load = 1'b0;
        in_valid = 1'b0;
        wait_ready();
        mult(16'h00FF, 24'h0002FD);

        // 5: sign-sensitive vectors
        load_coef(8'hFD);
        wait_ready();
        mult(16'h8000, EXP_8000_FD);
        load_coef(8'h05);
        wait_ready();
        mult(16'hFFFF, EXP_FFFF_05);
        load_coef(8'h80);
        wait_ready();
        mult(16'h7FFF, model(16'h7FFF, 8'h80));
        mult(16'hA5C3, model(16'hA5C3, 8'h80));
        mult(16'h0000, 24'h000000);

        // 6: reset during MUL
        start(16'h1234, model(16'h1234, 8'h80));
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_coef_busy", 32'(coef_busy), 32'd0);
        check("midrst_p_out", 32'(p_out), 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1;
        x_in = 16'h0011;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("postrst_in_ready", 32'(in_ready), 32'd0);
            check("postrst_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        load_coef(8'h04);
        wait_ready();
        mult(16'h0010, 24'h000040);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
